// File: rtl/vector_mem_unit_pkg.sv
// Shared definitions for the vector memory unit.
// Holds the vector geometry (also used by the VRF and the vector ALU), the
// operation encoding and the sequencer state encoding.
package vector_mem_unit_pkg;

    localparam int LANES  = 4;
    localparam int LANE_W = 8;
    localparam int VEC_W  = LANES * LANE_W;

    // Operation select, sampled together with start.
    localparam logic OP_VLOAD  = 1'b0;
    localparam logic OP_VSTORE = 1'b1;

    typedef logic [1:0] lane_idx_t;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LD_ISSUE = 3'd1,
        S_LD_DRAIN = 3'd2,
        S_LD_WB    = 3'd3,
        S_ST_ISSUE = 3'd4,
        S_ST_DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/vector_mem_unit_lane_pack.sv
// vec_lane_pack: 4 x 8b vector holding register.
// Ports:
//   clock, reset   : clock, asynchronous active-high reset (clears vector)
//   load/load_data : overwrite the whole vector (has priority over insert)
//   ins_en/ins_idx/ins_byte : write one byte into lane ins_idx
//   sel_idx/sel_byte : combinational read of lane sel_idx
//   vec            : current vector contents
module vec_lane_pack
    import vector_mem_unit_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic [VEC_W-1:0]  load_data,
    input  logic              ins_en,
    input  lane_idx_t         ins_idx,
    input  logic [LANE_W-1:0] ins_byte,
    input  lane_idx_t         sel_idx,
    output logic [LANE_W-1:0] sel_byte,
    output logic [VEC_W-1:0]  vec
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vec <= '0;
        end else if (load) begin
            vec <= load_data;
        end else if (ins_en) begin
            vec[ins_idx*LANE_W +: LANE_W] <= ins_byte;
        end
    end

    assign sel_byte = vec[sel_idx*LANE_W +: LANE_W];

endmodule

// File: rtl/vector_mem_unit.sv
// vector_mem_unit: multicycle vector load/store sequencer between the
// byte-wide data memory and the vector register file.
//   VLOAD : reads base..base+3 (synchronous RAM, data one cycle after
//           mem_read), assembles a 32b vector, writes it to the VRF, done.
//   VSTORE: writes the latched 32b vector to base..base+3, one byte per
//           cycle, then done.
// Handshake: start is accepted only in IDLE (also not in the done cycle);
// op_store, base_addr, vreg_dst and vdata_in are captured with it and
// ignored afterwards. done is a one-cycle pulse, busy covers every
// non-IDLE cycle including the done cycle.
// Ports:
//   clock, reset                     : clock, async active-high reset
//   start, op_store, base_addr, vreg_dst, vdata_in : request
//   mem_addr, mem_read, mem_write, mem_wdata, mem_rdata : memory side
//   vdataw, vregw, VRFWrite          : VRF write port
//   busy, done                       : status
module vector_mem_unit
    import vector_mem_unit_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              op_store,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [1:0]        vreg_dst,
    input  logic [VEC_W-1:0]  vdata_in,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [LANE_W-1:0] mem_wdata,
    input  logic [LANE_W-1:0] mem_rdata,
    output logic [VEC_W-1:0]  vdataw,
    output logic [1:0]        vregw,
    output logic              VRFWrite,
    output logic              busy,
    output logic              done
);

    state_t    state_q, state_d;
    lane_idx_t lane_q, lane_d;
    logic      accept;

    logic [ADDR_W-1:0] base_q;
    logic [1:0]        vreg_q;
    logic              cap_en_q;
    lane_idx_t         cap_idx_q;
    logic [VEC_W-1:0]  vdataw_q;
    logic [1:0]        vregw_q;

    logic [VEC_W-1:0]  pack_vec;
    logic [LANE_W-1:0] pack_sel;
    logic [VEC_W-1:0]  pack_load_data;

    // ---------------- FSM ----------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            lane_q  <= '0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        accept  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    lane_d  = '0;
                    state_d = (op_store == OP_VSTORE) ? S_ST_ISSUE : S_LD_ISSUE;
                end
            end
            S_LD_ISSUE: begin
                lane_d = lane_q + 2'd1;
                if (lane_q == 2'd3) state_d = S_LD_DRAIN;
            end
            S_LD_DRAIN: state_d = S_LD_WB;
            S_LD_WB:    state_d = S_IDLE;
            S_ST_ISSUE: begin
                lane_d = lane_q + 2'd1;
                if (lane_q == 2'd3) state_d = S_ST_DONE;
            end
            S_ST_DONE:  state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // ---------------- Datapath ----------------
    // Read data for the lane issued last cycle arrives now, so the capture
    // index is the lane counter delayed by one cycle. The last lane lands
    // during LD_DRAIN.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            base_q    <= '0;
            vreg_q    <= '0;
            cap_en_q  <= 1'b0;
            cap_idx_q <= '0;
            vdataw_q  <= '0;
            vregw_q   <= '0;
        end else begin
            if (accept) begin
                base_q <= base_addr;
                vreg_q <= vreg_dst;
            end
            cap_en_q  <= (state_q == S_LD_ISSUE);
            cap_idx_q <= lane_q;
            if (state_q == S_LD_WB) begin
                vdataw_q <= pack_vec;
                vregw_q  <= vreg_q;
            end
        end
    end

    // A load starts from an empty vector; a store preloads the store data.
    assign pack_load_data = (op_store == OP_VSTORE) ? vdata_in : '0;

    vec_lane_pack u_pack (
        .clock     (clock),
        .reset     (reset),
        .load      (accept),
        .load_data (pack_load_data),
        .ins_en    (cap_en_q),
        .ins_idx   (cap_idx_q),
        .ins_byte  (mem_rdata),
        .sel_idx   (lane_q),
        .sel_byte  (pack_sel),
        .vec       (pack_vec)
    );

    // ---------------- Outputs ----------------
    // Strobes decode from the state register only, so an asynchronous
    // reset drops them immediately.
    assign mem_read  = (state_q == S_LD_ISSUE);
    assign mem_write = (state_q == S_ST_ISSUE);
    assign mem_addr  = (mem_read || mem_write) ? (base_q + ADDR_W'(lane_q)) : '0;
    assign mem_wdata = mem_write ? pack_sel : '0;

    // During write-back the freshly assembled vector is presented directly;
    // afterwards the registered copy holds it.
    assign VRFWrite  = (state_q == S_LD_WB);
    assign vdataw    = VRFWrite ? pack_vec : vdataw_q;
    assign vregw     = VRFWrite ? vreg_q : vregw_q;
    assign done      = (state_q == S_LD_WB) || (state_q == S_ST_DONE);
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_vector_mem_unit.sv
// Directed bench for vector_mem_unit with a synchronous byte RAM model.
module tb_vector_mem_unit;

    logic        clock;
    logic        reset;
    logic        start;
    logic        op_store;
    logic [7:0]  base_addr;
    logic [1:0]  vreg_dst;
    logic [31:0] vdata_in;
    logic [7:0]  mem_addr;
    logic        mem_read;
    logic        mem_write;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic [31:0] vdataw;
    logic [1:0]  vregw;
    logic        VRFWrite;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;

    // {addr, byte} expected for each store cycle
    logic [15:0] exp_q[$];

    vector_mem_unit dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .op_store  (op_store),
        .base_addr (base_addr),
        .vreg_dst  (vreg_dst),
        .vdata_in  (vdata_in),
        .mem_addr  (mem_addr),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .vdataw    (vdataw),
        .vregw     (vregw),
        .VRFWrite  (VRFWrite),
        .busy      (busy),
        .done      (done)
    );

    // ---------------- clock ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- memory model ----------------
    logic [7:0] mem [256];
    logic       pre_we;
    logic [7:0] pre_addr;
    logic [7:0] pre_data;

    always @(posedge clock) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (mem_write) mem[mem_addr] <= mem_wdata;
        if (mem_read) mem_rdata <= mem[mem_addr];
    end

    // ---------------- checking ----------------
    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", tag, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        pre_we   = 1'b1;
        pre_addr = a;
        pre_data = d;
        @(negedge clock);
        pre_we   = 1'b0;
    endtask

    // Entered and left at a negedge with the DUT idle.
    task automatic run_load(input logic [7:0] base, input logic [1:0] vreg,
                            input logic [31:0] exp_vec);
        logic [7:0] ea;
        start     = 1'b1;
        op_store  = 1'b0;
        base_addr = base;
        vreg_dst  = vreg;
        vdata_in  = $urandom;
        @(negedge clock);
        start = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            ea = base + 8'(c - 1);
            if (c <= 4) begin
                check_val($sformatf("ld c%0d read", c), mem_read, 1);
                check_val($sformatf("ld c%0d addr", c), mem_addr, ea);
            end else begin
                check_val($sformatf("ld c%0d read", c), mem_read, 0);
                check_val($sformatf("ld c%0d addr", c), mem_addr, 0);
            end
            check_val($sformatf("ld c%0d write", c), mem_write, 0);
            check_val($sformatf("ld c%0d vrfwrite", c), VRFWrite, (c == 6) ? 1 : 0);
            check_val($sformatf("ld c%0d done", c), done, (c == 6) ? 1 : 0);
            check_val($sformatf("ld c%0d busy", c), busy, 1);
            if (c == 6) begin
                check_val("ld wb vdataw", vdataw, exp_vec);
                check_val("ld wb vregw", vregw, {30'd0, vreg});
            end
            base_addr = $urandom;
            vreg_dst  = 2'($urandom_range(0, 3));
            @(negedge clock);
        end
        check_val("ld after busy", busy, 0);
        check_val("ld after done", done, 0);
        check_val("ld hold vdataw", vdataw, exp_vec);
        check_val("ld hold vregw", vregw, {30'd0, vreg});
    endtask

    task automatic run_store(input logic [31:0] vdata, input logic [7:0] base,
                             input bit hold_start, input bit churn);
        logic [15:0] e;
        start     = 1'b1;
        op_store  = 1'b1;
        base_addr = base;
        vdata_in  = vdata;
        vreg_dst  = 2'($urandom_range(0, 3));
        for (int i = 0; i < 4; i++) exp_q.push_back({base + 8'(i), vdata[8*i +: 8]});
        @(negedge clock);
        if (!hold_start) start = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            if (c <= 4) begin
                e = exp_q.pop_front();
                check_val($sformatf("st c%0d write", c), mem_write, 1);
                check_val($sformatf("st c%0d addr", c), mem_addr, e[15:8]);
                check_val($sformatf("st c%0d wdata", c), mem_wdata, e[7:0]);
            end else begin
                check_val($sformatf("st c%0d write", c), mem_write, 0);
                check_val($sformatf("st c%0d addr", c), mem_addr, 0);
                check_val($sformatf("st c%0d wdata", c), mem_wdata, 0);
            end
            check_val($sformatf("st c%0d read", c), mem_read, 0);
            check_val($sformatf("st c%0d vrfwrite", c), VRFWrite, 0);
            check_val($sformatf("st c%0d done", c), done, (c == 5) ? 1 : 0);
            check_val($sformatf("st c%0d busy", c), busy, 1);
            if (churn) begin
                base_addr = $urandom;
                vdata_in  = $urandom;
            end
            @(negedge clock);
        end
        start = 1'b0;
        check_val("st after busy", busy, 0);
        check_val("st after done", done, 0);
        for (int i = 0; i < 4; i++)
            check_val($sformatf("st mem[%0d]", i), mem[base + 8'(i)], vdata[8*i +: 8]);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        op_store  = 1'b0;
        base_addr = '0;
        vreg_dst  = '0;
        vdata_in  = '0;
        pre_we    = 1'b0;
        pre_addr  = '0;
        pre_data  = '0;
        #1;
        check_val("rst mem_read", mem_read, 0);
        check_val("rst mem_write", mem_write, 0);
        check_val("rst mem_addr", mem_addr, 0);
        check_val("rst mem_wdata", mem_wdata, 0);
        check_val("rst vdataw", vdataw, 0);
        check_val("rst vregw", vregw, 0);
        check_val("rst vrfwrite", VRFWrite, 0);
        check_val("rst busy", busy, 0);
        check_val("rst done", done, 0);

        @(negedge clock);
        preload(8'h10, 8'h11); preload(8'h11, 8'h22);
        preload(8'h12, 8'h33); preload(8'h13, 8'h44);
        preload(8'hFE, 8'h01); preload(8'hFF, 8'h02);
        preload(8'h00, 8'h03); preload(8'h01, 8'h04);
        preload(8'h30, 8'hA1); preload(8'h31, 8'hB2);
        preload(8'h32, 8'hC3); preload(8'h33, 8'hD4);
        reset = 1'b0;
        @(negedge clock);

        run_load(8'h10, 2'd2, 32'h44332211);
        run_store(32'hDEADBEEF, 8'h20, 1'b0, 1'b0);
        run_load(8'hFE, 2'd1, 32'h04030201);
        // start held through the whole store, then a load starts straight away
        run_store(32'hCAFEF00D, 8'h40, 1'b1, 1'b0);
        run_load(8'h10, 2'd3, 32'h44332211);
        run_store(32'h12345678, 8'h80, 1'b0, 1'b1);

        // reset during cycle 3 of a load
        start     = 1'b1;
        op_store  = 1'b0;
        base_addr = 8'h30;
        vreg_dst  = 2'd1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check_val("mid c3 read", mem_read, 1);
        check_val("mid c3 addr", mem_addr, 8'h32);
        reset = 1'b1;
        #1;
        check_val("mid rst read", mem_read, 0);
        check_val("mid rst addr", mem_addr, 0);
        check_val("mid rst busy", busy, 0);
        check_val("mid rst done", done, 0);
        check_val("mid rst vrfwrite", VRFWrite, 0);
        check_val("mid rst vdataw", vdataw, 0);
        check_val("mid rst vregw", vregw, 0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            if (c == 1) reset = 1'b0;
            check_val($sformatf("mid post c%0d vrfwrite", c), VRFWrite, 0);
            check_val($sformatf("mid post c%0d busy", c), busy, 0);
        end
        run_load(8'h30, 2'd1, 32'hD4C3B2A1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
